// File: rtl/pointer_mem_access_if.sv
// Request, label-table lookup and memory bus signals of pointer_mem_access.
// The slave modport is the view taken by the access engine itself.
interface pointer_mem_access_if;
    logic        req;
    logic        rw;
    logic [11:0] lbid;
    logic [15:0] ofs;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [11:0] lt_lbid;
    logic [15:0] lt_base;
    logic [15:0] lt_size;
    logic        lt_valid;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output req, rw, lbid, ofs, wdata, lt_base, lt_size, lt_valid, mem_ready, mem_rdata,
        input  busy, ack, err, rdata, lt_lbid, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, rw, lbid, ofs, wdata, lt_base, lt_size, lt_valid, mem_ready, mem_rdata,
        output busy, ack, err, rdata, lt_lbid, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pointer_mem_access.sv
// Bounds-checked pointer load/store engine: label lookup, range check, then one
// memory access with a wait-cycle timeout. All outputs are registered.
module pointer_mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    pointer_mem_access_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, ACCESS, DONE} state_t;

    state_t        state;
    logic          rw_q;
    logic [15:0]   ofs_q;
    logic [31:0]   wdata_q;
    logic [15:0]   base_q;
    logic [15:0]   size_q;
    logic          valid_q;
    logic [CW-1:0] wait_cnt;

    logic          busy_q;
    logic          ack_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic [11:0]   lt_lbid_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [15:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;

    logic [16:0]   sum;
    logic          fault;
    logic          timeout_hit;

    always_comb begin
        sum         = {1'b0, base_q} + {1'b0, ofs_q};
        fault       = !valid_q || (ofs_q >= size_q) || sum[16];
        // True on the wait cycle whose increment would make the count reach TIMEOUT.
        timeout_hit = (32'(wait_cnt) + 32'd1) >= TIMEOUT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rw_q        <= 1'b0;
            ofs_q       <= '0;
            wdata_q     <= '0;
            base_q      <= '0;
            size_q      <= '0;
            valid_q     <= 1'b0;
            wait_cnt    <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            lt_lbid_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (bus.req) begin
                        lt_lbid_q <= bus.lbid;
                        ofs_q     <= bus.ofs;
                        rw_q      <= bus.rw;
                        wdata_q   <= bus.wdata;
                        busy_q    <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    base_q  <= bus.lt_base;
                    size_q  <= bus.lt_size;
                    valid_q <= bus.lt_valid;
                    state   <= CHECK;
                end
                CHECK: begin
                    if (fault) begin
                        err_q <= 1'b1;
                        ack_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_addr_q  <= sum[15:0];
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= rw_q;
                        mem_wdata_q <= wdata_q;
                        wait_cnt    <= '0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!rw_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b0;
                        ack_q     <= 1'b1;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                        ack_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.lt_lbid   = lt_lbid_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
